// File: rtl/tx_os_scheduler.sv
// Transmit ordered-set / packet scheduler: arbitrates EIOS, SKP, TS2, TS1, DLLP, TLP
// requests into packet assembly one item at a time, with a free-running SKP interval timer.
package tx_os_pkg;
  typedef enum logic [2:0] {
    RATE_2P5  = 3'd0,
    RATE_5P0  = 3'd1,
    RATE_8P0  = 3'd2,
    RATE_16P0 = 3'd3,
    RATE_32P0 = 3'd4
  } active_data_rate_e;

  typedef enum logic [2:0] {
    OS_NONE = 3'd0,
    OS_TS1  = 3'd1,
    OS_TS2  = 3'd2,
    OS_SKP  = 3'd3,
    OS_EIOS = 3'd4,
    OS_DLLP = 3'd5,
    OS_TLP  = 3'd6
  } os_type_e;
endpackage

module tx_os_scheduler
  import tx_os_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  active_data_rate_e active_data_rate_i,
  input  logic              controller_bypass_scrambler_i,
  input  logic              skp_tick_i,
  input  logic              eios_req_i,
  input  logic              ts2_req_i,
  input  logic              ts1_req_i,
  input  logic              dllp_req_i,
  input  logic              tlp_req_i,
  output logic [4:0]        gnt_o,
  input  logic              asm_ready_i,
  input  logic              asm_done_i,
  output logic              os_start_o,
  output logic [2:0]        os_type_o,
  output logic              scramble_en_o,
  output logic              elec_idle_o
);

  localparam int CW = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, EIOS_GAP} state_e;

  state_e   state, state_nxt;
  os_type_e cur_type, cur_type_nxt;
  os_type_e win, type_out;
  logic     eios_two, eios_two_nxt;
  logic     eidle, eidle_nxt;
  logic     start, skp_gnt, skp_due, cand;
  logic [4:0]    gnt, win_gnt;
  logic [CW-1:0] skp_cnt;
  logic [1:0]    skp_pend;

  assign skp_due = skp_tick_i && (skp_cnt == CW'(SKP_INTERVAL - 1));

  // Fixed priority; SKP carries no grant bit since it is generated internally.
  always_comb begin
    win     = OS_NONE;
    win_gnt = '0;
    if (eios_req_i) begin
      win     = OS_EIOS;
      win_gnt = 5'b00001;
    end else if (skp_pend != 2'd0) begin
      win     = OS_SKP;
    end else if (ts2_req_i) begin
      win     = OS_TS2;
      win_gnt = 5'b00010;
    end else if (ts1_req_i) begin
      win     = OS_TS1;
      win_gnt = 5'b00100;
    end else if (dllp_req_i) begin
      win     = OS_DLLP;
      win_gnt = 5'b01000;
    end else if (tlp_req_i) begin
      win     = OS_TLP;
      win_gnt = 5'b10000;
    end
    cand = (win != OS_NONE);
  end

  always_comb begin
    state_nxt    = state;
    cur_type_nxt = cur_type;
    eios_two_nxt = eios_two;
    eidle_nxt    = eidle;
    start        = 1'b0;
    type_out     = OS_NONE;
    gnt          = '0;
    skp_gnt      = 1'b0;
    case (state)
      IDLE: begin
        if (cand && asm_ready_i) begin
          start        = 1'b1;
          type_out     = win;
          gnt          = win_gnt;
          skp_gnt      = (win == OS_SKP);
          cur_type_nxt = win;
          // Rate is sampled at grant time only; an in-flight EIOS keeps its sequence length.
          eios_two_nxt = (win == OS_EIOS) && (active_data_rate_i == RATE_5P0);
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        type_out = cur_type;
        if (asm_done_i) begin
          if (cur_type == OS_EIOS && eios_two) begin
            state_nxt = EIOS_GAP;
          end else begin
            state_nxt = IDLE;
            if (cur_type == OS_EIOS) eidle_nxt = 1'b1;
          end
        end
      end
      EIOS_GAP: begin
        if (asm_ready_i) begin
          start        = 1'b1;
          type_out     = OS_EIOS;
          eios_two_nxt = 1'b0;
          state_nxt    = BUSY;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (start && type_out != OS_EIOS) eidle_nxt = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cur_type <= OS_NONE;
      eios_two <= 1'b0;
      eidle    <= 1'b0;
      skp_cnt  <= '0;
      skp_pend <= '0;
    end else begin
      state    <= state_nxt;
      cur_type <= cur_type_nxt;
      eios_two <= eios_two_nxt;
      eidle    <= eidle_nxt;
      if (skp_tick_i) skp_cnt <= skp_due ? '0 : skp_cnt + 1'b1;
      if (skp_due && !skp_gnt && skp_pend != 2'd2) skp_pend <= skp_pend + 1'b1;
      else if (!skp_due && skp_gnt)                skp_pend <= skp_pend - 1'b1;
    end
  end

  // Outputs are masked while reset is sampled so an abandoned item emits nothing.
  assign os_start_o    = start & ~rst_i;
  assign gnt_o         = rst_i ? 5'b00000 : gnt;
  assign os_type_o     = rst_i ? OS_NONE : type_out;
  assign scramble_en_o = !rst_i && !controller_bypass_scrambler_i &&
                         (type_out == OS_DLLP || type_out == OS_TLP);
  assign elec_idle_o   = eidle & ~rst_i;

endmodule

// File: doc/tx_os_scheduler.md
TX_OS_SCHEDULER -- requirements
Module: tx_os_scheduler

Interface
REQ-001 The block SHALL have parameter SKP_INTERVAL, default 1180, meaning the number of skp_tick_i cycles between SKP ordered-set requests.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock.
REQ-003 The block SHALL have port rst_i, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port active_data_rate_i, input, active_data_rate_e, the current link data rate.
REQ-005 The block SHALL have port controller_bypass_scrambler_i, input, 1, which forces scrambling off.
REQ-006 The block SHALL have port skp_tick_i, input, 1, a per-symbol-time enable for the SKP timer.
REQ-007 The block SHALL have ports eios_req_i, ts2_req_i, ts1_req_i, dllp_req_i and tlp_req_i, each input, 1, each a level request held until granted.
REQ-008 The block SHALL have port gnt_o, output, 5, a one-hot grant pulse with bit order {tlp, dllp, ts1, ts2, eios} from [4] to [0].
REQ-009 The block SHALL have port asm_ready_i, input, 1, asserted when packet assembly can accept a start.
REQ-010 The block SHALL have port asm_done_i, input, 1, a pulse on the last symbol of the current set or packet.
REQ-011 The block SHALL have port os_start_o, output, 1, a one-cycle start command to packet assembly.
REQ-012 The block SHALL have port os_type_o, output, 3, encoded as 0 NONE, 1 TS1, 2 TS2, 3 SKP, 4 EIOS, 5 DLLP, 6 TLP.
REQ-013 The block SHALL have port scramble_en_o, output, 1, the scrambler enable for the current item.
REQ-014 The block SHALL have port elec_idle_o, output, 1, asserted once the EIOS sequence has completed.

Function
REQ-015 The FSM SHALL have the states IDLE, BUSY and EIOS_GAP.
REQ-016 IDLE: a candidate SHALL exist when skp_pend>0 or any req_i is high.
REQ-017 IDLE: when a candidate exists and asm_ready_i=1, the block SHALL, in the same cycle, assert os_start_o=1, drive os_type_o with the winner, pulse the winner's gnt_o bit, and go to BUSY.
REQ-018 Winner priority SHALL be EIOS > SKP > TS2 > TS1 > DLLP > TLP.
REQ-019 A SKP grant SHALL drive gnt_o=0 and decrement skp_pend.
REQ-020 IDLE with no candidate or asm_ready_i=0 SHALL drive os_start_o=0, gnt_o=0 and os_type_o=NONE.
REQ-021 BUSY: os_type_o SHALL hold the granted type, and the block SHALL stay in BUSY until asm_done_i=1.
REQ-022 BUSY on asm_done_i for an EIOS at 5.0 GT/s, first set only: the block SHALL go to EIOS_GAP.
REQ-023 BUSY on asm_done_i in every other case: the block SHALL go to IDLE, so the earliest next os_start_o is 2 cycles after the previous os_start_o.
REQ-024 EIOS_GAP: the block SHALL wait for asm_ready_i, then pulse os_start_o with os_type_o=EIOS and no gnt_o pulse, then go to BUSY (second EIOS, giving the EIOSQ of 2).
REQ-025 At 2.5, 8.0, 16.0 and 32.0 GT/s the EIOSQ SHALL be 1 EIOS.
REQ-026 asm_done_i in IDLE or EIOS_GAP SHALL be ignored.
REQ-027 SKP timer: a counter of width $clog2(SKP_INTERVAL) SHALL increment on skp_tick_i and wrap to 0 at SKP_INTERVAL-1, setting a due pulse on the wrap.
REQ-028 skp_pend (2 bits) SHALL increment on the due pulse, saturating at 2, and decrement on a SKP grant.
REQ-029 A due pulse and a SKP grant in the same cycle SHALL leave skp_pend unchanged.
REQ-030 The SKP timer SHALL run in all states.
REQ-031 SKP SHALL only be granted in IDLE, so it is never inserted inside a TLP, DLLP or other set.
REQ-032 scramble_en_o SHALL be 1 only while os_type_o is DLLP or TLP and controller_bypass_scrambler_i=0, and 0 otherwise, computed combinationally from os_type_o.
REQ-033 elec_idle_o SHALL set on asm_done_i of the final EIOS of the EIOSQ.
REQ-034 elec_idle_o SHALL clear on the next os_start_o of a non-EIOS type.
REQ-035 An active_data_rate_i change SHALL take effect at the next grant decision; an in-flight item is not altered.

Reset
REQ-036 On rst_i=1 sampled at a clock edge, the block SHALL return to IDLE and clear the SKP counter and skp_pend to 0.
REQ-037 During reset, outputs SHALL be os_start_o=0, os_type_o=NONE, gnt_o=0, scramble_en_o=0 and elec_idle_o=0.
REQ-038 Reset asserted mid-BUSY SHALL abandon the item without issuing a gnt_o or os_start_o.
REQ-039 The first grant after reset SHALL be possible 1 cycle after rst_i deasserts.

Verification
REQ-040 Scenario: ts1_req_i=1, asm_ready_i=1, asm_done_i every 16 cycles -> os_start_o and gnt_o[2] pulse every 17 cycles, os_type_o=1, scramble_en_o=0.
REQ-041 Scenario: SKP_INTERVAL=8, skp_tick_i=1, tlp_req_i=1, asm_done_i 20 cycles after start -> skp_pend saturates at 2, then two SKP grants (type 3) occur before the next TLP, and there is no SKP start during BUSY.
REQ-042 Scenario: eios_req_i and tlp_req_i asserted together at 5.0 GT/s -> EIOS granted, two EIOS starts with one gnt_o[0] pulse, elec_idle_o=1 after the second done, TLP granted next and elec_idle_o cleared at that start.
REQ-043 Scenario: the same EIOS stimulus at 2.5 GT/s -> a single EIOS start and elec_idle_o=1 after the first done.
REQ-044 Scenario: dllp_req_i=1 with controller_bypass_scrambler_i toggled -> scramble_en_o equals the inverse of the bypass input while os_type_o=5.
REQ-045 Scenario: rst_i pulsed 3 cycles into BUSY -> next cycle IDLE, skp_pend=0, all outputs at reset values, and a fresh grant on the following cycle.
